// File: rtl/sfft_readout_buffer.sv
// Double-buffered SFFT frame readout: captures bin frames into a back bank and
// exposes a coherent front bank plus status/sample words on an 8-bit byte bus.
module sfft_readout_buffer #(
  parameter int NFFT       = 128,
  parameter int BIN_WIDTH  = 32,
  parameter int TIME_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NFFT*BIN_WIDTH-1:0] bins_in,
  input  logic                      bins_valid,
  input  logic [23:0]               sample_in,
  input  logic                      sample_valid,
  input  logic                      chipselect,
  input  logic                      read,
  input  logic                      write,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [7:0]                writedata,
  output logic [7:0]                readdata,
  output logic                      frame_ready
);

  localparam int IDX_W  = (NFFT > 1) ? $clog2(NFFT) : 1;
  localparam int WORD_W = ADDR_WIDTH - 2;

  logic [BIN_WIDTH-1:0]  bank [2][NFFT];
  logic [TIME_WIDTH-1:0] bank_time [2];
  logic [TIME_WIDTH-1:0] frame_cnt;
  logic                  ptr;
  logic                  back_full;
  logic                  ready;
  logic                  overrun;
  logic [7:0]            drop_cnt;
  logic [23:0]           sample;

  logic                  ack;
  logic                  promote;
  logic                  drop;
  logic                  wr_bank;
  logic [WORD_W-1:0]     word_idx;
  logic [IDX_W-1:0]      bin_idx;
  logic [31:0]           word_val;
  logic [7:0]            byte_val;

  // A capture coinciding with promotion lands in the old front, which becomes the back bank.
  always_comb begin
    ack     = chipselect && write && (address == ADDR_WIDTH'(4)) && writedata[0];
    promote = back_full && !ready && !chipselect;
    drop    = bins_valid && back_full && !promote;
    wr_bank = promote ? ptr : ~ptr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      ptr       <= 1'b0;
      back_full <= 1'b0;
      ready     <= 1'b0;
      overrun   <= 1'b0;
      drop_cnt  <= 8'd0;
      sample    <= 24'd0;
      for (int b = 0; b < 2; b++) begin
        bank_time[b] <= '0;
        for (int i = 0; i < NFFT; i++) bank[b][i] <= '0;
      end
    end else begin
      if (promote) begin
        ptr   <= ~ptr;
        ready <= 1'b1;
      end else if (ack) begin
        ready <= 1'b0;
      end

      if (bins_valid) begin
        frame_cnt          <= frame_cnt + TIME_WIDTH'(1);
        bank_time[wr_bank] <= frame_cnt + TIME_WIDTH'(1);
        for (int i = 0; i < NFFT; i++) bank[wr_bank][i] <= bins_in[i*BIN_WIDTH +: BIN_WIDTH];
        back_full <= 1'b1;
      end else if (promote) begin
        back_full <= 1'b0;
      end

      // A drop in the acknowledge cycle restarts the count at one.
      if (drop) begin
        overrun  <= 1'b1;
        drop_cnt <= ack ? 8'd1 : ((drop_cnt == 8'hFF) ? 8'hFF : drop_cnt + 8'd1);
      end else if (ack) begin
        overrun  <= 1'b0;
        drop_cnt <= 8'd0;
      end

      if (sample_valid && !chipselect) sample <= sample_in;
    end
  end

  always_comb begin
    word_idx = address[ADDR_WIDTH-1:2];
    bin_idx  = IDX_W'(32'(word_idx) - 32'd4);
    word_val = 32'h0;
    if (word_idx == WORD_W'(0)) begin
      word_val = 32'(bank_time[ptr]);
    end else if (word_idx == WORD_W'(1)) begin
      word_val = {16'h0, drop_cnt, 6'h0, overrun, ready};
    end else if (word_idx == WORD_W'(2)) begin
      word_val = {{8{sample[23]}}, sample};
    end else if (word_idx == WORD_W'(3)) begin
      word_val = 32'h0123_4567;
    end else if ((32'(word_idx) >= 32'd4) && (32'(word_idx) < 32'(NFFT) + 32'd4)) begin
      word_val = 32'(bank[ptr][bin_idx]);
    end else begin
      word_val = 32'h0;
    end
    case (address[1:0])
      2'd0:    byte_val = word_val[7:0];
      2'd1:    byte_val = word_val[15:8];
      2'd2:    byte_val = word_val[23:16];
      default: byte_val = word_val[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 8'd0;
    end else if (chipselect && read) begin
      readdata <= byte_val;
    end
  end

  assign frame_ready = ready;

endmodule

// File: tb/tb_sfft_readout_buffer.sv
// Scoreboard bench for sfft_readout_buffer: a frame-level reference model predicts
// every read byte and frame_ready; a monitor compares them against the DUT.
module tb_sfft_readout_buffer;
  localparam int NFFT = 128;
  localparam int BW   = 32;
  localparam int TW   = 32;
  localparam int AW   = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NFFT*BW-1:0] bins_in;
  logic              bins_valid;
  logic [23:0]       sample_in;
  logic              sample_valid;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [AW-1:0]     address;
  logic [7:0]        writedata;
  logic [7:0]        readdata;
  logic              frame_ready;

  sfft_readout_buffer #(.NFFT(NFFT), .BIN_WIDTH(BW), .TIME_WIDTH(TW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .bins_in(bins_in), .bins_valid(bins_valid),
    .sample_in(sample_in), .sample_valid(sample_valid), .chipselect(chipselect),
    .read(read), .write(write), .address(address), .writedata(writedata),
    .readdata(readdata), .frame_ready(frame_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: whole frames copied between "displayed" and "pending" slots.
  int unsigned m_cnt;
  logic [31:0] m_front [NFFT];
  logic [31:0] m_pend  [NFFT];
  int unsigned m_front_cnt, m_pend_cnt;
  bit          m_back_full, m_ready, m_overrun;
  int          m_drops;
  logic [23:0] m_sample;

  logic [7:0] exp_rd_q [$];
  bit         exp_rdy_q [$];
  logic       mon_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [AW-1:0] a);
    int unsigned w;
    logic [31:0] v;
    w = int'(a) / 4;
    if (w == 0)             v = m_front_cnt;
    else if (w == 1)        v = {16'h0, 8'(m_drops), 6'h0, m_overrun, m_ready};
    else if (w == 2)        v = {{8{m_sample[23]}}, m_sample};
    else if (w == 3)        v = 32'h0123_4567;
    else if (w < 4 + NFFT)  v = m_front[w-4];
    else                    v = 32'h0;
    return v[8*int'(a[1:0]) +: 8];
  endfunction

  task automatic model_step();
    bit ack, prom, drop;
    if (reset) begin
      m_cnt = 0; m_front_cnt = 0; m_pend_cnt = 0;
      m_back_full = 0; m_ready = 0; m_overrun = 0; m_drops = 0; m_sample = 24'd0;
      for (int i = 0; i < NFFT; i++) begin m_front[i] = 32'd0; m_pend[i] = 32'd0; end
      return;
    end
    ack  = chipselect && write && (address == 16'd4) && writedata[0];
    prom = m_back_full && !m_ready && !chipselect;
    drop = bins_valid && m_back_full && !prom;
    if (prom) begin
      m_front = m_pend; m_front_cnt = m_pend_cnt; m_ready = 1; m_back_full = 0;
    end
    if (ack) m_ready = 0;
    if (bins_valid) begin
      m_cnt++;
      m_pend_cnt = m_cnt;
      for (int i = 0; i < NFFT; i++) m_pend[i] = bins_in[i*BW +: BW];
      m_back_full = 1;
    end
    if (drop) begin
      m_overrun = 1;
      m_drops = ack ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
    end else if (ack) begin
      m_overrun = 0; m_drops = 0;
    end
    if (sample_valid && !chipselect) m_sample = sample_in;
  endtask

  // One clock: push expectations from the pre-edge model state, then advance the model.
  task automatic tick(input bit fx = 1'b0, input logic [7:0] fv = 8'h0);
    if (chipselect && read) exp_rd_q.push_back(reset ? 8'h00 : (fx ? fv : model_byte(address)));
    model_step();
    exp_rdy_q.push_back(m_ready);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    reset = 0; bins_valid = 0; sample_valid = 0; chipselect = 0; read = 0; write = 0;
    address = '0; writedata = 8'h0;
  endtask

  task automatic rd_const(input int a, input logic [7:0] v);
    chipselect = 1; read = 1; write = 0; address = AW'(a);
    tick(1'b1, v);
  endtask

  task automatic ack_write();
    chipselect = 1; read = 0; write = 1; address = 16'd4; writedata = 8'h01;
    tick();
    write = 0;
  endtask

  task automatic ramp_bins();
    for (int i = 0; i < NFFT; i++) bins_in[i*BW +: BW] = 32'(i + 1);
  endtask

  task automatic rand_bins();
    for (int i = 0; i < NFFT; i++) bins_in[i*BW +: BW] = $urandom;
  endtask

  always @(posedge clk) begin
    mon_rd = chipselect && read;
    #1;
    if (exp_rdy_q.size() > 0) check("frame_ready", 32'(frame_ready), 32'(exp_rdy_q.pop_front()));
    if (mon_rd) begin
      if (exp_rd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL read_unexpected actual=%h required=none", readdata);
      end else begin
        check("readdata", 32'(readdata), 32'(exp_rd_q.pop_front()));
      end
    end
  end

  initial begin
    bit in_burst;
    quiet();
    bins_in = '0; sample_in = 24'h0;
    reset = 1;
    @(negedge clk);
    tick(); tick();
    quiet();

    // Reset image of the first four words
    for (int a = 0; a < 16; a++)
      rd_const(a, (a == 12) ? 8'h67 : (a == 13) ? 8'h45 : (a == 14) ? 8'h23 : (a == 15) ? 8'h01 : 8'h00);
    quiet(); tick();
    check("frame_ready_reset", 32'(frame_ready), 32'd0);

    // Single frame with ramp bins
    ramp_bins(); bins_valid = 1; tick(); bins_valid = 0; tick();
    check("frame_ready_after_two", 32'(frame_ready), 32'd1);
    rd_const(0, 8'h01); rd_const(1, 8'h00); rd_const(2, 8'h00); rd_const(3, 8'h00);
    rd_const(36, 8'h06); rd_const(37, 8'h00); rd_const(38, 8'h00); rd_const(39, 8'h00);
    rd_const(4, 8'h01); rd_const(5, 8'h00);

    // Capture during a burst must not disturb the front frame
    rand_bins(); bins_valid = 1; rd_const(0, 8'h01); bins_valid = 0;
    rd_const(36, 8'h06); rd_const(0, 8'h01); rd_const(4, 8'h01);
    ack_write(); quiet(); tick();
    rd_const(0, 8'h02); quiet(); tick();

    // Three captures without acknowledge: third overwrites the second
    reset = 1; tick(); quiet();
    ramp_bins();
    bins_valid = 1; tick(); bins_valid = 0; tick(); tick();
    bins_valid = 1; tick(); tick(); bins_valid = 0;
    rd_const(0, 8'h01); rd_const(4, 8'h03); rd_const(5, 8'h01);
    ack_write(); quiet(); tick();
    rd_const(0, 8'h03); rd_const(4, 8'h01); rd_const(5, 8'h00);
    quiet();

    // Drop counter saturation
    bins_valid = 1;
    repeat (300) tick();
    bins_valid = 0;
    rd_const(5, 8'hFF); rd_const(4, 8'h03);

    // Reset collides with a capture inside a read burst
    chipselect = 1; read = 1; bins_valid = 1; address = 16'd0; reset = 1;
    tick(1'b1, 8'h00);
    reset = 0; bins_valid = 0;
    for (int a = 0; a < 8; a++) rd_const(a, 8'h00);
    quiet(); tick();
    check("frame_ready_after_reset", 32'(frame_ready), 32'd0);

    // Randomized traffic against the model
    in_burst = 0;
    for (int c = 0; c < 3000; c++) begin
      quiet();
      reset = ($urandom_range(0, 499) == 0);
      bins_valid = ($urandom_range(0, 5) == 0);
      if (bins_valid) rand_bins();
      sample_valid = ($urandom_range(0, 2) == 0);
      sample_in = 24'($urandom);
      if (in_burst) in_burst = ($urandom_range(0, 5) != 0);
      else in_burst = ($urandom_range(0, 3) == 0);
      chipselect = in_burst;
      if (in_burst) begin
        if ($urandom_range(0, 7) == 0) begin
          write = 1;
          address = ($urandom_range(0, 1) == 0) ? 16'd4 : AW'($urandom_range(0, 600));
          writedata = 8'($urandom);
        end else begin
          read = ($urandom_range(0, 3) != 0);
          address = ($urandom_range(0, 15) == 0) ? AW'($urandom) : AW'($urandom_range(0, 4*(NFFT+4)+15));
        end
      end
      tick();
    end

    quiet(); tick(); tick();
    check("scoreboard_drained", 32'(exp_rd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
